// File: rtl/gray_pkg.sv
// gray_pkg: definitions shared by the Gray counter receive side and its benches.
//   state_t    - tracker FSM encoding (IDLE / TRACK / FAULT)
//   S0..S7     - the 3-bit Gray sequence in counting order
package gray_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_TRACK = 2'b01,
    ST_FAULT = 2'b10
  } state_t;

  localparam logic [2:0] S0 = 3'b000;
  localparam logic [2:0] S1 = 3'b001;
  localparam logic [2:0] S2 = 3'b011;
  localparam logic [2:0] S3 = 3'b010;
  localparam logic [2:0] S4 = 3'b110;
  localparam logic [2:0] S5 = 3'b111;
  localparam logic [2:0] S6 = 3'b101;
  localparam logic [2:0] S7 = 3'b100;

endpackage

// File: rtl/gray_tracker_if.sv
// gray_tracker_if: bundle between a Gray count source and the tracker.
//   master modport (source / bench): drives Valid, Gray, Clear; observes status.
//   slave modport (gray_tracker):    samples Valid, Gray, Clear; drives
//     Binary, Step, Wrap, Overflow, WrapCount, Locked, Error.
interface gray_tracker_if #(
  parameter int W     = 3,
  parameter int CNT_W = 8
);
  logic             Valid;
  logic [W-1:0]     Gray;
  logic             Clear;
  logic [W-1:0]     Binary;
  logic             Step;
  logic             Wrap;
  logic             Overflow;
  logic [CNT_W-1:0] WrapCount;
  logic             Locked;
  logic             Error;

  modport master (
    output Valid, Gray, Clear,
    input  Binary, Step, Wrap, Overflow, WrapCount, Locked, Error
  );

  modport slave (
    input  Valid, Gray, Clear,
    output Binary, Step, Wrap, Overflow, WrapCount, Locked, Error
  );
endinterface

// File: rtl/gray2bin.sv
// gray2bin: combinational Gray-to-binary converter.
//   gray   - W-bit Gray-coded input
//   binary - W-bit binary equivalent
// Each binary bit is the XOR of all Gray bits at or above its position, which
// avoids a bit-to-bit dependency chain inside one vector.
module gray2bin #(
  parameter int W = 3
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] binary
);

  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    assign binary[gi] = ^gray[W-1:gi];
  end

endmodule

// File: rtl/gray_tracker.sv
// gray_tracker: decoder and integrity monitor for a sampled Gray counter.
//   Clk    - clock, all logic on posedge
//   Reset  - synchronous, active-low
//   bus    - gray_tracker_if slave:
//            Valid/Gray sample strobe and word, Clear restarts tracking;
//            Binary last accepted value, Step/Wrap one-cycle pulses,
//            Overflow sticky wrap flag, WrapCount saturating wrap count,
//            Locked while tracking, Error after an illegal transition.
module gray_tracker
  import gray_pkg::*;
#(
  parameter int W     = 3,
  parameter int CNT_W = 8
) (
  input  logic           Clk,
  input  logic           Reset,
  gray_tracker_if.slave  bus
);

  localparam logic [W-1:0]     BIN_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_reg, state_next;
  logic [W-1:0]     binary_reg, binary_next;
  logic             step_reg, step_next;
  logic             wrap_reg, wrap_next;
  logic             overflow_reg, overflow_next;
  logic [CNT_W-1:0] wrap_count_reg, wrap_count_next;
  logic             locked_reg, locked_next;
  logic             error_reg, error_next;

  logic [W-1:0]     bin_new;
  logic [W-1:0]     delta;

  gray2bin #(.W(W)) u_gray2bin (
    .gray   (bus.Gray),
    .binary (bin_new)
  );

  // Binary always equals the previous accepted sample, so it doubles as the
  // reference for the step check. Subtraction wraps modulo 2^W.
  assign delta = bin_new - binary_reg;

  always_comb begin
    state_next      = state_reg;
    binary_next     = binary_reg;
    step_next       = 1'b0;
    wrap_next       = 1'b0;
    overflow_next   = overflow_reg;
    wrap_count_next = wrap_count_reg;

    if (bus.Clear) begin
      // Binary is intentionally kept; a Valid in this cycle is dropped.
      state_next      = ST_IDLE;
      overflow_next   = 1'b0;
      wrap_count_next = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.Valid) begin
            binary_next = bin_new;
            state_next  = ST_TRACK;
          end
        end
        ST_TRACK: begin
          if (bus.Valid) begin
            if (delta == '0) begin
              // hold: nothing changes
            end else if (delta == W'(1)) begin
              binary_next = bin_new;
              step_next   = 1'b1;
              if (binary_reg == BIN_MAX) begin
                wrap_next     = 1'b1;
                overflow_next = 1'b1;
                if (wrap_count_reg != CNT_MAX) begin
                  wrap_count_next = wrap_count_reg + CNT_W'(1);
                end
              end
            end else begin
              state_next = ST_FAULT;
            end
          end
        end
        ST_FAULT: begin
          // frozen until Clear
        end
        default: state_next = ST_IDLE;
      endcase
    end

    locked_next = (state_next == ST_TRACK);
    error_next  = (state_next == ST_FAULT);
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_reg      <= ST_IDLE;
      binary_reg     <= '0;
      step_reg       <= 1'b0;
      wrap_reg       <= 1'b0;
      overflow_reg   <= 1'b0;
      wrap_count_reg <= '0;
      locked_reg     <= 1'b0;
      error_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      binary_reg     <= binary_next;
      step_reg       <= step_next;
      wrap_reg       <= wrap_next;
      overflow_reg   <= overflow_next;
      wrap_count_reg <= wrap_count_next;
      locked_reg     <= locked_next;
      error_reg      <= error_next;
    end
  end

  assign bus.Binary    = binary_reg;
  assign bus.Step      = step_reg;
  assign bus.Wrap      = wrap_reg;
  assign bus.Overflow  = overflow_reg;
  assign bus.WrapCount = wrap_count_reg;
  assign bus.Locked    = locked_reg;
  assign bus.Error     = error_reg;

endmodule
